// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector stimulus/check slice.
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  // Encoding matches the "two consecutive ones" detector under test.
  typedef enum logic [1:0] {
    D_S0 = 2'b00,
    D_S1 = 2'b01,
    D_S2 = 2'b10
  } det_state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic det_state_t det_next(input det_state_t s, input logic a);
    if (!a) begin
      return D_S0;
    end
    return (s == D_S0) ? D_S1 : D_S2;
  endfunction

endpackage

// File: rtl/seq_det_model.sv
// Golden "two consecutive ones" detector; exp_y is a Moore output of the registered state.
module seq_det_model
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic exp_y
);

  det_state_t state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= D_S0;
    end else begin
      state_q <= det_next(state_q, a);
    end
  end

  assign exp_y = (state_q == D_S2);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter with idle gap, plus a lockstep checker comparing the
// detector's y against the golden model and counting mismatches.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_bits,
  input  logic [LEN_W-1:0]   in_len,
  input  logic [GAP_W-1:0]   in_gap,
  output logic               a,
  output logic               a_valid,
  output logic               frame_done,
  input  logic               y_in,
  input  logic               chk_en,
  output logic               exp_y,
  output logic               mismatch,
  output logic [7:0]         err_count
);

  tx_state_t          state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               a_q, a_d;
  logic               a_valid_q, a_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               mismatch_q, mismatch_d;
  logic [7:0]         err_q, err_d;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
  assign in_ready    = (state_q == TX_IDLE);

  // a_q holds the bit on the wire; shreg_q holds the bits still to come.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    a_d          = 1'b0;
    a_valid_d    = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (in_valid) begin
          gap_d = in_gap;
          if (len_clamped != '0) begin
            a_d       = in_bits[0];
            a_valid_d = 1'b1;
            shreg_d   = in_bits >> 1;
            cnt_d     = len_clamped;
            state_d   = TX_SHIFT;
          end else begin
            frame_done_d = 1'b1;
            state_d      = (in_gap != '0) ? TX_GAP : TX_IDLE;
          end
        end
      end
      TX_SHIFT: begin
        if (cnt_q > LEN_W'(1)) begin
          a_d       = shreg_q[0];
          a_valid_d = 1'b1;
          shreg_d   = shreg_q >> 1;
          cnt_d     = cnt_q - LEN_W'(1);
        end else begin
          cnt_d        = '0;
          frame_done_d = 1'b1;
          state_d      = (gap_q != '0) ? TX_GAP : TX_IDLE;
        end
      end
      TX_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    mismatch_d = chk_en && (y_in != exp_y);
    err_d      = err_q;
    if (mismatch_d && (err_q != ERR_MAX)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      a_q          <= 1'b0;
      a_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      a_q          <= a_d;
      a_valid_q    <= a_valid_d;
      frame_done_q <= frame_done_d;
      mismatch_q   <= mismatch_d;
      err_q        <= err_d;
    end
  end

  assign a          = a_q;
  assign a_valid    = a_valid_q;
  assign frame_done = frame_done_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;

  seq_det_model u_model (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_q),
    .exp_y (exp_y)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: framing, model alignment, checker and saturation.
module tb_seq_pattern_tx;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned LenW   = 5;
  localparam int unsigned GapW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [MaxLen-1:0] in_bits;
  logic [LenW-1:0]   in_len;
  logic [GapW-1:0]   in_gap;
  logic              a;
  logic              a_valid;
  logic              frame_done;
  logic              y_in;
  logic              chk_en;
  logic              exp_y;
  logic              mismatch;
  logic [7:0]        err_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .MAX_LEN (MaxLen),
    .LEN_W   (LenW),
    .GAP_W   (GapW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_len     (in_len),
    .in_gap     (in_gap),
    .a          (a),
    .a_valid    (a_valid),
    .frame_done (frame_done),
    .y_in       (y_in),
    .chk_en     (chk_en),
    .exp_y      (exp_y),
    .mismatch   (mismatch),
    .err_count  (err_count)
  );

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [MaxLen-1:0] bits, input logic [LenW-1:0] len,
                       input logic [GapW-1:0] gap);
    in_bits  = bits;
    in_len   = len;
    in_gap   = gap;
    in_valid = 1'b1;
  endtask

  logic [6:1] t1_a, t1_av, t1_ey, t1_fd, t1_ir;
  logic [8:1] t2_a, t2_av, t2_ey, t2_fd, t2_ir, t2_mm;
  logic [9:1] t3_a, t3_av, t3_ir;
  int         nav;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bits  = '0;
    in_len   = '0;
    in_gap   = '0;
    y_in     = 1'b0;
    chk_en   = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst a", int'(a), 0);
    check("rst a_valid", int'(a_valid), 0);
    check("rst frame_done", int'(frame_done), 0);
    check("rst mismatch", int'(mismatch), 0);
    check("rst err_count", int'(err_count), 0);
    check("rst exp_y", int'(exp_y), 0);
    rst_n = 1'b1;
    tick();
    check("rst in_ready", int'(in_ready), 1);

    // 4'b0110, len 4, gap 0, correct detector
    t1_a  = 6'b000110;
    t1_av = 6'b001111;
    t1_ey = 6'b001000;
    t1_fd = 6'b010000;
    t1_ir = 6'b110000;
    chk_en = 1'b1;
    y_in   = 1'b0;
    offer(16'h0006, 5'd4, 4'd0);
    check("p0110 ready c0", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      y_in = t1_ey[c];
      check($sformatf("p0110 a c%0d", c), int'(a), int'(t1_a[c]));
      check($sformatf("p0110 a_valid c%0d", c), int'(a_valid), int'(t1_av[c]));
      check($sformatf("p0110 exp_y c%0d", c), int'(exp_y), int'(t1_ey[c]));
      check($sformatf("p0110 frame_done c%0d", c), int'(frame_done), int'(t1_fd[c]));
      check($sformatf("p0110 in_ready c%0d", c), int'(in_ready), int'(t1_ir[c]));
      check($sformatf("p0110 mismatch c%0d", c), int'(mismatch), 0);
    end
    check("p0110 err_count", int'(err_count), 0);

    // 4'b0011, len 4, gap 2, detector stuck in S2 once reached
    t2_a  = 8'b00000011;
    t2_av = 8'b00001111;
    t2_ey = 8'b00000100;
    t2_fd = 8'b00010000;
    t2_ir = 8'b11000000;
    t2_mm = 8'b11110000;
    y_in  = 1'b0;
    offer(16'h0003, 5'd4, 4'd2);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      y_in = (c >= 3);
      check($sformatf("stuck a c%0d", c), int'(a), int'(t2_a[c]));
      check($sformatf("stuck a_valid c%0d", c), int'(a_valid), int'(t2_av[c]));
      check($sformatf("stuck exp_y c%0d", c), int'(exp_y), int'(t2_ey[c]));
      check($sformatf("stuck frame_done c%0d", c), int'(frame_done), int'(t2_fd[c]));
      check($sformatf("stuck in_ready c%0d", c), int'(in_ready), int'(t2_ir[c]));
      check($sformatf("stuck mismatch c%0d", c), int'(mismatch), int'(t2_mm[c]));
      check($sformatf("stuck err_count c%0d", c), int'(err_count), (c >= 5) ? c - 4 : 0);
    end
    chk_en = 1'b0;
    tick();
    check("chk off mismatch", int'(mismatch), 0);
    check("chk off err_count", int'(err_count), 4);
    tick();
    check("chk off err_count hold", int'(err_count), 4);

    // Reset mid-frame
    y_in = 1'b0;
    offer(16'h00FF, 5'd8, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrst a_valid before", int'(a_valid), 1);
    rst_n = 1'b0;
    tick();
    check("midrst a", int'(a), 0);
    check("midrst a_valid", int'(a_valid), 0);
    check("midrst in_ready", int'(in_ready), 1);
    check("midrst err_count", int'(err_count), 0);
    check("midrst frame_done", int'(frame_done), 0);
    check("midrst exp_y", int'(exp_y), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("postrst frame_done c%0d", c), int'(frame_done), 0);
      check($sformatf("postrst a_valid c%0d", c), int'(a_valid), 0);
      check($sformatf("postrst in_ready c%0d", c), int'(in_ready), 1);
      check($sformatf("postrst a c%0d", c), int'(a), 0);
    end

    // len 0, gap 0
    offer(16'hFFFF, 5'd0, 4'd0);
    tick();
    in_valid = 1'b0;
    check("len0 frame_done", int'(frame_done), 1);
    check("len0 a_valid", int'(a_valid), 0);
    check("len0 a", int'(a), 0);
    check("len0 in_ready", int'(in_ready), 1);
    tick();
    check("len0 frame_done end", int'(frame_done), 0);

    // len 0, gap 2
    offer(16'h0000, 5'd0, 4'd2);
    tick();
    in_valid = 1'b0;
    check("len0g2 frame_done", int'(frame_done), 1);
    check("len0g2 in_ready c1", int'(in_ready), 0);
    tick();
    check("len0g2 in_ready c2", int'(in_ready), 0);
    tick();
    check("len0g2 in_ready c3", int'(in_ready), 1);

    // len 20 clamps to 16
    offer(16'hFFFF, 5'd20, 4'd0);
    tick();
    in_valid = 1'b0;
    nav = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      if (a_valid) nav++;
      if (c == 16) check("len20 in_ready c16", int'(in_ready), 0);
      if (c == 17) begin
        check("len20 in_ready c17", int'(in_ready), 1);
        check("len20 frame_done c17", int'(frame_done), 1);
      end
    end
    check("len20 a_valid cycles", nav, 16);

    // Back-to-back, in_valid held: 4'b1101 len 4, then 3'b011 len 3
    t3_a  = 9'b001101101;
    t3_av = 9'b011101111;
    t3_ir = 9'b100010000;
    offer(16'h000D, 5'd4, 4'd0);
    tick();
    in_bits = 16'h0003;
    in_len  = 5'd3;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      if (c == 6) in_valid = 1'b0;
      check($sformatf("b2b a c%0d", c), int'(a), int'(t3_a[c]));
      check($sformatf("b2b a_valid c%0d", c), int'(a_valid), int'(t3_av[c]));
      check($sformatf("b2b in_ready c%0d", c), int'(in_ready), int'(t3_ir[c]));
      check($sformatf("b2b frame_done c%0d", c), int'(frame_done), int'(t3_ir[c]));
    end

    // Saturation with idle a and y forced high
    tick();
    tick();
    chk_en = 1'b1;
    y_in   = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256 || k == 300) begin
        check($sformatf("sat err_count k%0d", k), int'(err_count), (k > 255) ? 255 : k);
        check($sformatf("sat mismatch k%0d", k), int'(mismatch), 1);
      end
    end
    chk_en = 1'b0;
    y_in   = 1'b0;
    tick();
    tick();
    check("sat hold err_count", int'(err_count), 255);
    check("sat quiet mismatch", int'(mismatch), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter and response checker for the single-bit sequence-detector FSMs in our formal/simulation sample set. It accepts a pattern word over a valid/ready handshake and shifts it out LSB-first on the detector's `a` input, followed by a programmable idle gap. A lockstep golden detector model runs alongside it and compares the detector's `y` output every cycle, counting mismatches. It drives stimulus for the "two consecutive ones" detector and produces FAIL evidence (mismatch pulses and VCD-visible counters) when the detector is faulty.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field.
- `GAP_W`, 4: width of the idle-gap field.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset. Sampled only on a rising `clk` edge.
- `in_valid` in 1: a pattern is offered.
- `in_ready` out 1: the transmitter can accept a pattern.
- `in_bits` in MAX_LEN: pattern bits, LSB transmitted first.
- `in_len` in LEN_W: number of bits to send. Values above MAX_LEN clamp to MAX_LEN.
- `in_gap` in GAP_W: number of idle cycles (a=0) after the frame.
- `a` out 1: serial bit to the detector, registered.
- `a_valid` out 1: high while `a` carries a frame bit.
- `frame_done` out 1: 1-cycle pulse after the last frame bit.
- `y_in` in 1: detector output under check.
- `chk_en` in 1: enables comparison.
- `exp_y` out 1: model's expected `y`.
- `mismatch` out 1: registered 1-cycle pulse per mismatch.
- `err_count` out 8: saturating mismatch count.

## Operation
- **Transmit FSM** `TX_IDLE`, `TX_SHIFT`, `TX_GAP`:
  - **TX_IDLE:** `in_ready` = 1, `a` = 0.
    - On `in_valid && in_ready`: latch bits, clamped length and gap.
    - If the length is nonzero, go to `TX_SHIFT`.
    - If the length is 0, pulse `frame_done` on the next cycle, then go to `TX_GAP` if gap > 0, else stay in `TX_IDLE`.
  - **TX_SHIFT:** `a` = `shreg[0]` and `a_valid` = 1. Shift right and decrement the bit count each cycle. After the last bit, go to `TX_GAP` if gap > 0, else `TX_IDLE`.
  - **TX_GAP:** `a` = 0 and `a_valid` = 0. Decrement gap each cycle. Go to `TX_IDLE` when the gap count reaches 0.
- `in_ready` = (state == `TX_IDLE`) only, so there is at least one idle cycle between frames.
- **Golden model**, states `D_S0`, `D_S1`, `D_S2`:
  - Samples `a` on every edge, including idle zeros.
  - S0: a → S1, else S0.
  - S1: a → S2, else S0.
  - S2: a → S2, else S0.
  - `exp_y` = (state == `D_S2`).
- **Checker:**
  - If `chk_en && (y_in != exp_y)` in cycle t, `mismatch` = 1 in cycle t+1.
  - `err_count` increments by one on the same edge and saturates at 255.
  - It clears only on reset.
- `chk_en` low: no mismatch pulses and no counting. The model still tracks `a`.

## Timing
- **Reset values:**
  - FSM `TX_IDLE`, model `D_S0`.
  - `a` = 0, `a_valid` = 0, `frame_done` = 0, `mismatch` = 0, `err_count` = 0, `exp_y` = 0.
  - `in_ready` = 1 in the first cycle after `rst_n` deasserts.
- **Reset mid-frame:** the frame is abandoned, with no `frame_done` pulse. All of the above reset values apply on the next cycle.
- **Latency:**
  - Accept at edge E0 puts bit 0 on `a` in the cycle after E0.
  - Bit k appears k cycles later.
  - `frame_done` is high in the cycle after the last bit.
  - A frame occupies 1 + len + gap cycles from accept to the next `in_ready`.
- **`exp_y` alignment:**
  - `exp_y` reflects `a` as sampled at the previous edges. It rises in the cycle after the second consecutive 1 is driven.
  - This matches a detector sharing `clk` whose active-high `rst` is tied to `~rst_n`.
- **Handshake:** `in_valid` may be held across `in_ready` = 0. A pattern is accepted only on a cycle with `in_valid && in_ready`.
- **Simultaneous events:** a mismatch and saturation on the same edge keep `err_count` at 255 and still pulse `mismatch`.

## Structure
- **Shared package `seq_pkg`:**
  - `tx_state_t` {TX_IDLE, TX_SHIFT, TX_GAP}.
  - `det_state_t` {D_S0=2'b00, D_S1=2'b01, D_S2=2'b10}, matching the detector encoding.
  - `ERR_MAX` = 8'd255.
- **Sub-module `seq_det_model`:** golden detector with ports clk, rst_n, a, exp_y. It is reused by other benches.
- The top-level holds the transmit FSM, shift register, counters and checker.

## Test plan
- **Reset mid-frame:** assert `rst_n` = 0 for 2 cycles during `TX_SHIFT` → `a` = 0, `in_ready` = 1, `err_count` = 0, no `frame_done`.
- **Pattern 4'b0110, len 4, gap 0, correct detector:**
  - `a` = 0,1,1,0 in cycles 1–4 after accept.
  - `exp_y` = 1 in cycle 4 only.
  - `frame_done` in cycle 5.
  - `mismatch` never asserts.
- **Pattern 4'b0011, len 4, gap 2, stuck-in-S2 detector, `chk_en` = 1:**
  - `exp_y` = 1 in cycle 3 and 0 in cycle 4.
  - `mismatch` asserts from cycle 5 on, one pulse per cycle.
  - `err_count` increments each cycle.
- **Length edge cases:**
  - len 0, gap 0 → `frame_done` the next cycle, `a_valid` stays 0.
  - len 20 with `in_bits` = 16'hFFFF → exactly 16 `a_valid` cycles.
- **Back-to-back frames:** `in_valid` held high for two frames with gap 0 → `in_ready` low for len cycles, exactly one `TX_IDLE` cycle between frames, both frames sent in order.
- **Counter saturation:** force `y_in` = 1 with `chk_en` = 1 and idle `a` for 300 cycles → `err_count` reaches 255 and holds, `mismatch` keeps pulsing.
